gf_horner_eval: RTL and testbench

- Streaming multi-root polynomial evaluator over GF(2^SYMB_WIDTH), using Horner's rule.
- Evaluates one received codeword at N_ROOTS consecutive powers of alpha in parallel. This produces the Reed-Solomon syndromes.
- Sits directly after the RS input interface and feeds the key-equation solver.
- Successor to the single combinational GF multiplier: constant-multiplier lanes, handshaked input and output, per-codeword accumulation.

---
 rtl/gf_horner_eval_if.sv | 27 ++
 rtl/gf_horner_eval.sv | 158 +++++++++++++++
 tb/tb_gf_horner_eval.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/gf_horner_eval_if.sv
// Handshake bundle for gf_horner_eval: symbol stream in, syndrome set out.
// slave = evaluator side, master = source/sink side.
`timescale 1ns/1ps
interface gf_horner_eval_if #(
    parameter int SYMB_WIDTH = 8,
    parameter int N_ROOTS    = 16
);
    logic                          s_valid;
    logic                          s_ready;
    logic [SYMB_WIDTH-1:0]         s_data;
    logic                          s_last;
    logic                          m_valid;
    logic                          m_ready;
    logic [N_ROOTS*SYMB_WIDTH-1:0] m_synd;
    logic                          m_zero;
    logic                          m_len_err;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_synd, m_zero, m_len_err
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_synd, m_zero, m_len_err
    );
endinterface

// File: rtl/gf_horner_eval.sv
// Multi-root Horner evaluator over GF(2^SYMB_WIDTH) producing RS syndromes.
// Ports: clk, rst_n (async low), bus (gf_horner_eval_if.slave):
//   s_valid/s_ready/s_data/s_last  codeword symbols, highest degree first
//   m_valid/m_ready/m_synd         syndrome set, lane i at [i*W +: W]
//   m_zero, m_len_err              all-zero flag, over-length flag
// Optional macro GF_HORNER_LEN_CHECK_EN enables the codeword length check.
`timescale 1ns/1ps
module gf_horner_eval #(
    parameter int          SYMB_WIDTH = 8,
    parameter int unsigned POLY       = 285,
    parameter int          N_ROOTS    = 16,
    parameter int          FIRST_ROOT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    gf_horner_eval_if.slave   bus
);
    localparam int W     = SYMB_WIDTH;
    localparam int ORDER = (1 << W) - 1;
    localparam logic [W-1:0] RED = POLY[W-1:0];

    // Multiply by alpha (x) with reduction by the field polynomial.
    function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? RED : '0);
    endfunction

    // alpha^e as a bit vector; used only for elaboration constants.
    function automatic logic [W-1:0] alpha_pow(input int e);
        logic [W-1:0] v;
        v = W'(1);
        for (int k = 0; k < e; k++) begin
            v = xtime(v);
        end
        return v;
    endfunction

    logic [N_ROOTS-1:0][W-1:0] acc_q;
    logic [N_ROOTS-1:0][W-1:0] acc_d;
    logic [N_ROOTS-1:0][W-1:0] synd_q;
    logic [W-1:0]              prod [N_ROOTS];
    logic                      first_q;
    logic                      alive_q;
    logic                      m_valid_q;
    logic                      zero_q;
    logic                      zero_d;
    logic                      acc_ok;
    logic                      acc_last;

    // Stall input only while a finished result waits for the sink.
    assign bus.s_ready = alive_q && !(m_valid_q && !bus.m_ready);
    assign acc_ok      = bus.s_valid && bus.s_ready;
    assign acc_last    = acc_ok && bus.s_last;

    // Constant multiplier lanes: bit j of acc contributes alpha^(e+j),
    // so each lane is a fixed XOR network over the accumulator bits.
    for (genvar i = 0; i < N_ROOTS; i++) begin : g_lane
        localparam int EXP = ((FIRST_ROOT + i) % ORDER + ORDER) % ORDER;
        logic [W-1:0] term [W];
        logic [W-1:0] lane_prod;

        for (genvar j = 0; j < W; j++) begin : g_col
            localparam logic [W-1:0] COL = alpha_pow(EXP + j);
            assign term[j] = acc_q[i][j] ? COL : '0;
        end

        always_comb begin
            lane_prod = '0;
            for (int j = 0; j < W; j++) begin
                lane_prod = lane_prod ^ term[j];
            end
        end

        assign prod[i] = lane_prod;
    end

    // Horner step; the first symbol of a codeword loads directly.
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < N_ROOTS; i++) begin
            acc_d[i] = first_q ? bus.s_data : (prod[i] ^ bus.s_data);
        end
        zero_d = (acc_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            synd_q    <= '0;
            first_q   <= 1'b1;
            alive_q   <= 1'b0;
            m_valid_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (acc_ok) begin
                if (bus.s_last) begin
                    acc_q   <= '0;
                    first_q <= 1'b1;
                    synd_q  <= acc_d;
                    zero_q  <= zero_d;
                end else begin
                    acc_q   <= acc_d;
                    first_q <= 1'b0;
                end
            end
            // A new result landing in the same cycle as a handshake
            // keeps m_valid high so results stream without a bubble.
            if (acc_last) begin
                m_valid_q <= 1'b1;
            end else if (m_valid_q && bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_synd  = synd_q;
    assign bus.m_zero  = zero_q;

`ifdef GF_HORNER_LEN_CHECK_EN
    localparam int CW = W + 1;

    logic [CW-1:0] len_q;
    logic [CW-1:0] len_d;
    logic          len_err_q;
    logic          len_err_d;

    // Saturating symbol count, including the symbol being accepted.
    always_comb begin
        len_d = len_q;
        if (first_q) begin
            len_d = CW'(1);
        end else if (!(&len_q)) begin
            len_d = len_q + CW'(1);
        end
        len_err_d = (len_d > CW'(ORDER));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            len_err_q <= 1'b0;
        end else if (acc_ok) begin
            if (bus.s_last) begin
                len_q     <= '0;
                len_err_q <= len_err_d;
            end else begin
                len_q     <= len_d;
            end
        end
    end

    assign bus.m_len_err = len_err_q;
`else
    assign bus.m_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf_horner_eval.sv
// Directed self-checking bench for gf_horner_eval (N_ROOTS=4, GF(256)).
// Expected syndromes are hand-derived powers of alpha under POLY 0x11D.
`timescale 1ns/1ps
module tb_gf_horner_eval;
    localparam int W  = 8;
    localparam int NR = 4;

`ifdef GF_HORNER_LEN_CHECK_EN
    localparam logic LEN_EXP = 1'b1;
`else
    localparam logic LEN_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gf_horner_eval_if #(.SYMB_WIDTH(W), .N_ROOTS(NR)) bus ();

    gf_horner_eval #(
        .SYMB_WIDTH(W),
        .POLY(285),
        .N_ROOTS(NR),
        .FIRST_ROOT(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one symbol at a negedge, wait for s_ready, complete the
    // handshake and return on the following negedge with s_valid low.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!bus.s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            n_cmp++;
            n_err++;
            $error("FAIL accept_timeout: observed s_ready 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_synd", bus.m_synd, 0);
        check("rst_m_zero", bus.m_zero, 0);
        check("rst_m_len_err", bus.m_len_err, 0);
        check("rst_s_ready", bus.s_ready, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", bus.s_ready, 1);

        // Single-symbol codeword: every syndrome equals the symbol.
        send(8'h01, 1'b1);
        check("single_valid", bus.m_valid, 1);
        check("single_synd", bus.m_synd, 32'h01010101);
        check("single_zero", bus.m_zero, 0);
        @(negedge clk);
        check("single_clear", bus.m_valid, 0);

        // [01,00] evaluates x at alpha^i.
        send(8'h01, 1'b0);
        send(8'h00, 1'b1);
        check("pow_synd", bus.m_synd, 32'h08040201);
        check("pow_zero", bus.m_zero, 0);
        idle(1);

        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        check("zero_synd", bus.m_synd, 0);
        check("zero_flag", bus.m_zero, 1);
        idle(1);

        // Stall the result and keep the next codeword pending.
        bus.m_ready = 1'b0;
        send(8'h01, 1'b0);
        send(8'h00, 1'b1);
        check("stall_valid", bus.m_valid, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h05;
        bus.s_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_s_ready", bus.s_ready, 0);
            check("stall_synd", bus.m_synd, 32'h08040201);
            check("stall_m_valid", bus.m_valid, 1);
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        check("b2b_valid", bus.m_valid, 1);
        check("b2b_synd", bus.m_synd, 32'h05050505);
        @(negedge clk);
        check("b2b_clear", bus.m_valid, 0);

        // alpha^7*alpha^(i) ^ 1: lanes 81,1C,3B,75.
        send(8'h80, 1'b0);
        idle(3);
        send(8'h01, 1'b1);
        check("gap_synd", bus.m_synd, 32'h753B1C81);
        idle(2);
        send(8'h80, 1'b0);
        send(8'h01, 1'b1);
        check("nogap_synd", bus.m_synd, 32'h753B1C81);
        idle(1);

        // Abort a codeword with reset; no residue may survive.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst_synd", bus.m_synd, 0);
        check("abort_rst_valid", bus.m_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h01, 1'b1);
        check("abort_synd", bus.m_synd, 32'h01010101);
        idle(1);

        // 256 symbols exceeds the maximum RS length of 255.
        for (int k = 0; k < 255; k++) begin
            send(8'h00, 1'b0);
        end
        send(8'h00, 1'b1);
        check("len256_err", bus.m_len_err, LEN_EXP);
        check("len256_synd", bus.m_synd, 0);
        check("len256_zero", bus.m_zero, 1);
        idle(1);

        for (int k = 0; k < 254; k++) begin
            send(8'h00, 1'b0);
        end
        send(8'h00, 1'b1);
        check("len255_err", bus.m_len_err, 0);
        check("len255_valid", bus.m_valid, 1);
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
